// File: rtl/pic_nchan_sync.sv
// pic_nchan_sync: clocked N-channel interrupt controller with fully nested
// priority, optional rotation, and a two-pulse INTA vector handshake.
module pic_nchan_sync #(
    parameter int unsigned NUM_IRQ     = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic               CS_n,
    input  logic               WR_n,
    input  logic               RD_n,
    input  logic [2:0]         ADDR,
    input  logic [DATA_W-1:0]  D_IN,
    output logic [DATA_W-1:0]  D_OUT,
    input  logic [NUM_IRQ-1:0] IR,
    input  logic               INTA_n,
    output logic               INT
);

    localparam int unsigned ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACK1  = 2'd1,
        S_WAIT2 = 2'd2,
        S_ACK2  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [NUM_IRQ-1:0]     ir_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] inta_sync;
    logic [NUM_IRQ-1:0]     ir_s;
    logic                   inta_s;
    logic [NUM_IRQ-1:0]     ir_prev;

    logic [2:0]         ctrl_q;
    logic [DATA_W-1:0]  vbase_q;
    logic [NUM_IRQ-1:0] imr_q;
    logic [NUM_IRQ-1:0] irr_q;
    logic [NUM_IRQ-1:0] isr_q;
    logic [ID_W-1:0]    lp_q;
    logic [ID_W-1:0]    id_q;
    logic               spur_q;

    logic               wr_en;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] pend_rot;
    logic [NUM_IRQ-1:0] isr_rot;
    logic [ID_W:0]      pend_top;
    logic [ID_W:0]      isr_top;
    logic               cand_valid;
    logic [ID_W-1:0]    cand_id;
    logic [ID_W-1:0]    isr_top_id;

    logic               ack1_enter;
    logic               ack2_exit;
    logic               vec_drive;

    logic               eoi_hit;
    logic [ID_W-1:0]    eoi_id;
    logic [NUM_IRQ-1:0] eoi_clr;
    logic               aeoi_hit;
    logic [NUM_IRQ-1:0] aeoi_clr;
    logic [NUM_IRQ-1:0] ack_set;

    logic               unused_din;

    assign unused_din = ^D_IN;
    assign wr_en      = !CS_n && !WR_n;
    assign ir_s       = ir_sync[SYNC_STAGES-1];
    assign inta_s     = inta_sync[SYNC_STAGES-1];

    // Lowest set bit of a rank-ordered vector, packed as {found, rank}.
    function automatic logic [ID_W:0] lowest_set(input logic [NUM_IRQ-1:0] v);
        logic [ID_W:0] r;
        r = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (v[i]) r = {1'b1, ID_W'(i)};
        end
        return r;
    endfunction

    // Map a priority rank back to a line number under the current pointer.
    function automatic logic [ID_W-1:0] rank_to_id(input logic [ID_W-1:0] rank,
                                                   input logic [ID_W-1:0] lp);
        int unsigned t;
        t = (32'(lp) + 32'(rank) + 32'd1) % NUM_IRQ;
        return ID_W'(t);
    endfunction

    // Input synchronisers; INTA_n chain resets to its idle (high) level so
    // reset release never looks like an acknowledge.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) ir_sync[s] <= '0;
            inta_sync <= '1;
        end else begin
            ir_sync[0] <= IR;
            for (int s = 1; s < int'(SYNC_STAGES); s++) ir_sync[s] <= ir_sync[s-1];
            inta_sync <= {inta_sync[SYNC_STAGES-2:0], INTA_n};
        end
    end

    // Rotated priority view: rank 0 is line (LP+1) mod N.
    always_comb begin
        pend     = irr_q & ~imr_q;
        pend_rot = '0;
        isr_rot  = '0;
        for (int unsigned k = 0; k < NUM_IRQ; k++) begin
            pend_rot[k] = pend[ID_W'((32'(lp_q) + k + 32'd1) % NUM_IRQ)];
            isr_rot[k]  = isr_q[ID_W'((32'(lp_q) + k + 32'd1) % NUM_IRQ)];
        end
        pend_top   = lowest_set(pend_rot);
        isr_top    = lowest_set(isr_rot);
        cand_valid = pend_top[ID_W] &&
                     (!isr_top[ID_W] || (pend_top[ID_W-1:0] < isr_top[ID_W-1:0]));
        cand_id    = rank_to_id(pend_top[ID_W-1:0], lp_q);
        isr_top_id = rank_to_id(isr_top[ID_W-1:0], lp_q);
    end

    // Acknowledge FSM state register.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Acknowledge FSM next state, driven by the synchronised INTA_n level.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (!inta_s) state_next = S_ACK1;
            S_ACK1:  if (inta_s)  state_next = S_WAIT2;
            S_WAIT2: if (!inta_s) state_next = S_ACK2;
            S_ACK2:  if (inta_s)  state_next = S_IDLE;
            default:              state_next = S_IDLE;
        endcase
    end

    // Acknowledge FSM outputs: latch strobe, vector drive, second-pulse end.
    always_comb begin
        ack1_enter = 1'b0;
        ack2_exit  = 1'b0;
        vec_drive  = 1'b0;
        case (state)
            S_IDLE:  ack1_enter = !inta_s;
            S_ACK2: begin
                vec_drive = 1'b1;
                ack2_exit = inta_s;
            end
            default: ;
        endcase
    end

    // EOI decode and auto-EOI; a non-specific EOI sees the pre-latch ISR.
    always_comb begin
        eoi_hit = 1'b0;
        eoi_id  = '0;
        eoi_clr = '0;
        if (wr_en && (ADDR == 3'd5)) begin
            if (D_IN[DATA_W-1]) begin
                if (isr_top[ID_W]) begin
                    eoi_hit = 1'b1;
                    eoi_id  = isr_top_id;
                end
            end else if ((32'(D_IN[ID_W-1:0]) < NUM_IRQ) && isr_q[D_IN[ID_W-1:0]]) begin
                eoi_hit = 1'b1;
                eoi_id  = D_IN[ID_W-1:0];
            end
            if (eoi_hit) eoi_clr = NUM_IRQ'(1) << eoi_id;
        end
        aeoi_hit = ack2_exit && ctrl_q[1] && !spur_q;
        aeoi_clr = aeoi_hit ? (NUM_IRQ'(1) << id_q) : '0;
        ack_set  = (ack1_enter && cand_valid) ? (NUM_IRQ'(1) << cand_id) : '0;
    end

    // Register file, request/service state, priority pointer and INT.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            ctrl_q  <= '0;
            vbase_q <= '0;
            imr_q   <= '1;
            irr_q   <= '0;
            isr_q   <= '0;
            lp_q    <= ID_W'(NUM_IRQ - 1);
            id_q    <= '0;
            spur_q  <= 1'b0;
            ir_prev <= '0;
            INT     <= 1'b0;
        end else begin
            ir_prev <= ir_s;
            if (wr_en) begin
                case (ADDR)
                    3'd0:    ctrl_q  <= D_IN[2:0];
                    3'd1:    vbase_q <= D_IN;
                    3'd2:    imr_q   <= D_IN[NUM_IRQ-1:0];
                    default: ;
                endcase
            end
            if (ctrl_q[0]) irr_q <= ir_s;
            else           irr_q <= (irr_q & ~ack_set) | (ir_s & ~ir_prev);
            isr_q <= (isr_q & ~eoi_clr & ~aeoi_clr) | ack_set;
            if (ack1_enter) begin
                id_q   <= cand_valid ? cand_id : ID_W'(NUM_IRQ - 1);
                spur_q <= !cand_valid;
            end
            if (ctrl_q[2] && eoi_hit)       lp_q <= eoi_id;
            else if (ctrl_q[2] && aeoi_hit) lp_q <= id_q;
            INT <= (state == S_IDLE) && (state_next == S_IDLE) && cand_valid;
        end
    end

    // Read mux; the vector overrides it during the second acknowledge pulse.
    always_comb begin
        D_OUT = '0;
        if (vec_drive) begin
            D_OUT = vbase_q + DATA_W'(id_q);
        end else if (!CS_n && !RD_n) begin
            case (ADDR)
                3'd0:    D_OUT = DATA_W'(ctrl_q);
                3'd1:    D_OUT = vbase_q;
                3'd2:    D_OUT = DATA_W'(imr_q);
                3'd3:    D_OUT = DATA_W'(irr_q);
                3'd4:    D_OUT = DATA_W'(isr_q);
                3'd6:    D_OUT = DATA_W'(lp_q);
                default: D_OUT = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_pic_nchan_sync.sv
// Directed bench for pic_nchan_sync with default parameters (8 lines, 8-bit bus).
module tb_pic_nchan_sync;

    logic       CLK;
    logic       RST_n;
    logic       CS_n;
    logic       WR_n;
    logic       RD_n;
    logic [2:0] ADDR;
    logic [7:0] D_IN;
    logic [7:0] D_OUT;
    logic [7:0] IR;
    logic       INTA_n;
    logic       INT;

    int n_tests = 0;
    int n_fail  = 0;

    pic_nchan_sync dut (
        .CLK    (CLK),
        .RST_n  (RST_n),
        .CS_n   (CS_n),
        .WR_n   (WR_n),
        .RD_n   (RD_n),
        .ADDR   (ADDR),
        .D_IN   (D_IN),
        .D_OUT  (D_OUT),
        .IR     (IR),
        .INTA_n (INTA_n),
        .INT    (INT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input logic exp);
        check(tag, {7'b0, INT}, {7'b0, exp});
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        CS_n = 1'b0; WR_n = 1'b0; ADDR = a; D_IN = d;
        cyc(1);
        CS_n = 1'b1; WR_n = 1'b1;
    endtask

    task automatic chk_reg(input string tag, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] d;
        CS_n = 1'b0; RD_n = 1'b0; ADDR = a;
        #1;
        d = D_OUT;
        CS_n = 1'b1; RD_n = 1'b1;
        check(tag, d, exp);
    endtask

    task automatic do_reset();
        RST_n = 1'b0;
        cyc(2);
        RST_n = 1'b1;
        cyc(1);
    endtask

    task automatic setup(input logic [7:0] ctrl);
        do_reset();
        wr(3'd2, 8'h00);
        wr(3'd1, 8'h20);
        wr(3'd0, ctrl);
    endtask

    // Edge-mode pulse; INT is high when this returns.
    task automatic pulse_ir(input logic [7:0] m);
        IR = m;
        cyc(2);
        IR = 8'h00;
        cyc(2);
    endtask

    task automatic inta1();
        INTA_n = 1'b0;
        cyc(4);
        INTA_n = 1'b1;
        cyc(3);
    endtask

    task automatic inta2_lo();
        INTA_n = 1'b0;
        cyc(3);
    endtask

    task automatic inta2_hi();
        INTA_n = 1'b1;
        cyc(3);
    endtask

    initial begin
        RST_n = 1'b0; CS_n = 1'b1; WR_n = 1'b1; RD_n = 1'b1;
        ADDR = 3'd0; D_IN = 8'h00; IR = 8'h00; INTA_n = 1'b1;
        cyc(2);
        check_int("rst_int", 1'b0);
        check("rst_dout", D_OUT, 8'h00);
        RST_n = 1'b1;
        cyc(1);
        chk_reg("rst_ctrl", 3'd0, 8'h00);
        chk_reg("rst_vbase", 3'd1, 8'h00);
        chk_reg("rst_imr", 3'd2, 8'hFF);
        cyc(1);
        chk_reg("rst_irr", 3'd3, 8'h00);
        chk_reg("rst_isr", 3'd4, 8'h00);
        chk_reg("rst_lp", 3'd6, 8'h07);
        wr(3'd7, 8'h5A);
        chk_reg("rsvd", 3'd7, 8'h00);

        // 1: IR[3] latency and vector
        wr(3'd2, 8'h00);
        wr(3'd1, 8'h20);
        IR = 8'h08;
        cyc(3);
        chk_reg("t1_irr", 3'd3, 8'h08);
        check_int("t1_int_early", 1'b0);
        cyc(1);
        check_int("t1_int", 1'b1);
        IR = 8'h00;
        inta1();
        check_int("t1_int_ack1", 1'b0);
        chk_reg("t1_isr", 3'd4, 8'h08);
        chk_reg("t1_irr_clr", 3'd3, 8'h00);
        inta2_lo();
        check("t1_vec", D_OUT, 8'h23);
        inta2_hi();
        chk_reg("t1_isr_hold", 3'd4, 8'h08);
        wr(3'd5, 8'h80);
        chk_reg("t1_isr_eoi", 3'd4, 8'h00);
        cyc(2);
        check_int("t1_int_idle", 1'b0);

        // 2: nested priority, IR[2] before IR[5]
        pulse_ir(8'h24);
        check_int("t2_int", 1'b1);
        chk_reg("t2_irr", 3'd3, 8'h24);
        inta1();
        chk_reg("t2_isr", 3'd4, 8'h04);
        chk_reg("t2_irr_ack", 3'd3, 8'h20);
        inta2_lo();
        check("t2_vec", D_OUT, 8'h22);
        inta2_hi();
        cyc(2);
        check_int("t2_int_nested", 1'b0);
        wr(3'd5, 8'h80);
        check_int("t2_int_eoi_edge", 1'b0);
        cyc(1);
        check_int("t2_int_after_eoi", 1'b1);
        chk_reg("t2_isr_eoi", 3'd4, 8'h00);
        inta1();
        inta2_lo();
        check("t2_vec5", D_OUT, 8'h25);
        inta2_hi();
        wr(3'd5, 8'h05);
        chk_reg("t2_isr_spec", 3'd4, 8'h00);

        // 3: rotation on EOI
        setup(8'h04);
        pulse_ir(8'h01);
        check_int("t3_int", 1'b1);
        inta1();
        inta2_lo();
        check("t3_vec0", D_OUT, 8'h20);
        inta2_hi();
        wr(3'd5, 8'h80);
        chk_reg("t3_lp0", 3'd6, 8'h00);
        wr(3'd5, 8'h80);
        chk_reg("t3_lp_noop", 3'd6, 8'h00);
        pulse_ir(8'h03);
        check_int("t3_int2", 1'b1);
        inta1();
        chk_reg("t3_isr", 3'd4, 8'h02);
        inta2_lo();
        check("t3_vec1", D_OUT, 8'h21);
        inta2_hi();
        wr(3'd5, 8'h80);
        cyc(1);
        check_int("t3_int_pend0", 1'b1);
        chk_reg("t3_lp1", 3'd6, 8'h01);
        inta1();
        inta2_lo();
        check("t3_vec0b", D_OUT, 8'h20);
        inta2_hi();

        // 4: auto-EOI
        setup(8'h02);
        pulse_ir(8'hC0);
        check_int("t4_int", 1'b1);
        inta1();
        chk_reg("t4_isr", 3'd4, 8'h40);
        inta2_lo();
        check("t4_vec6", D_OUT, 8'h26);
        inta2_hi();
        chk_reg("t4_isr_aeoi", 3'd4, 8'h00);
        check_int("t4_int_exit", 1'b0);
        cyc(1);
        check_int("t4_int_reassert", 1'b1);
        inta1();
        inta2_lo();
        check("t4_vec7", D_OUT, 8'h27);
        inta2_hi();
        chk_reg("t4_isr_end", 3'd4, 8'h00);
        chk_reg("t4_irr_end", 3'd3, 8'h00);

        // 5: spurious acknowledge, reset during ACK2, async INT reset
        setup(8'h00);
        pulse_ir(8'h08);
        inta1();
        inta2_lo();
        check("t5_vec3", D_OUT, 8'h23);
        inta2_hi();
        cyc(2);
        check_int("t5_int_none", 1'b0);
        inta1();
        chk_reg("t5_isr_spur", 3'd4, 8'h08);
        chk_reg("t5_irr_spur", 3'd3, 8'h00);
        inta2_lo();
        check("t5_vec_spur", D_OUT, 8'h27);
        inta2_hi();
        chk_reg("t5_isr_after", 3'd4, 8'h08);
        pulse_ir(8'h02);
        check_int("t5_int_ir1", 1'b1);
        inta1();
        chk_reg("t5_isr_nest", 3'd4, 8'h0A);
        inta2_lo();
        check("t5_vec1", D_OUT, 8'h21);
        RST_n = 1'b0;
        #1;
        check("t5_rst_dout", D_OUT, 8'h00);
        check_int("t5_rst_int", 1'b0);
        INTA_n = 1'b1;
        chk_reg("t5_rst_isr", 3'd4, 8'h00);
        cyc(1);
        RST_n = 1'b1;
        cyc(1);
        chk_reg("t5_rst_imr", 3'd2, 8'hFF);
        wr(3'd2, 8'h00);
        pulse_ir(8'h04);
        check_int("t5_int_ir2", 1'b1);
        RST_n = 1'b0;
        #1;
        check_int("t5_int_async", 1'b0);
        cyc(1);
        RST_n = 1'b1;
        cyc(1);

        // 6: level mode and masking
        setup(8'h01);
        IR = 8'h10;
        cyc(4);
        check_int("t6_int", 1'b1);
        chk_reg("t6_irr", 3'd3, 8'h10);
        inta1();
        chk_reg("t6_isr", 3'd4, 8'h10);
        chk_reg("t6_irr_level", 3'd3, 8'h10);
        inta2_lo();
        check("t6_vec4", D_OUT, 8'h24);
        inta2_hi();
        cyc(2);
        check_int("t6_int_blocked", 1'b0);
        wr(3'd5, 8'h04);
        cyc(1);
        check_int("t6_int_reassert", 1'b1);
        chk_reg("t6_isr_eoi", 3'd4, 8'h00);
        wr(3'd2, 8'h10);
        cyc(1);
        check_int("t6_int_masked", 1'b0);
        cyc(3);
        check_int("t6_int_masked_hold", 1'b0);
        IR = 8'h00;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
